pio_osr: RTL

//  Output shift register of a PIO state machine; the reading end of the 4-deep TX fifo.

---
 rtl/pio_pkg.sv | 18 +
 rtl/pio_osr_if.sv | 35 +++
 rtl/pio_osr_shifter.sv | 33 +++
 rtl/pio_osr.sv | 112 +++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared types and constants for the PIO state-machine datapath blocks.
//   osr_state_t : output shift register control state
//   eff_count   : maps a 5-bit count field to 1..32 (0 encodes 32)
package pio_pkg;

    localparam int PIO_DATA_W = 32;
    localparam int PIO_CNT_W  = 6;

    typedef enum logic [0:0] {
        READY     = 1'b0,
        PULL_WAIT = 1'b1
    } osr_state_t;

    function automatic logic [PIO_CNT_W-1:0] eff_count(input logic [4:0] c);
        return (c == 5'd0) ? 6'd32 : {1'b0, c};
    endfunction

endpackage

// File: rtl/pio_osr_if.sv
// Bundles the TX fifo read side and the SM core OUT/PULL side of the OSR.
//   master : fifo + core side (drives requests, fifo flags/data)
//   slave  : the OSR itself (drives pull strobe, OUT result, stall, count)
interface pio_osr_if;
    import pio_pkg::*;

    logic                  fifo_empty;
    logic [PIO_DATA_W-1:0] fifo_dout;
    logic                  fifo_pull;
    logic                  shift_right;
    logic                  autopull;
    logic [4:0]            pull_thresh;
    logic                  out_req;
    logic [4:0]            out_count;
    logic                  pull_req;
    logic                  pull_block;
    logic [PIO_DATA_W-1:0] x_data;
    logic [PIO_DATA_W-1:0] out_data;
    logic                  out_valid;
    logic                  stall;
    logic [PIO_CNT_W-1:0]  shift_count;

    modport master (
        output fifo_empty, fifo_dout, shift_right, autopull, pull_thresh,
               out_req, out_count, pull_req, pull_block, x_data,
        input  fifo_pull, out_data, out_valid, stall, shift_count
    );

    modport slave (
        input  fifo_empty, fifo_dout, shift_right, autopull, pull_thresh,
               out_req, out_count, pull_req, pull_block, x_data,
        output fifo_pull, out_data, out_valid, stall, shift_count
    );

endinterface

// File: rtl/pio_osr_shifter.sv
// Combinational OUT extract/shift.
//   osr         : current shift register contents
//   n           : bit count, 1..32
//   shift_right : 1 takes LSBs and shifts right, 0 takes MSBs and shifts left
//   data        : extracted bits, zero-extended
//   next_osr    : register contents after the shift
module pio_osr_shifter
    import pio_pkg::*;
(
    input  logic [PIO_DATA_W-1:0] osr,
    input  logic [PIO_CNT_W-1:0]  n,
    input  logic                  shift_right,
    output logic [PIO_DATA_W-1:0] data,
    output logic [PIO_DATA_W-1:0] next_osr
);

    always_comb begin
        data     = '0;
        next_osr = '0;
        // Full-word case handled explicitly so the register always empties to zero.
        if (n >= 6'd32) begin
            data     = osr;
            next_osr = '0;
        end else if (shift_right) begin
            data     = osr & ((32'd1 << n) - 32'd1);
            next_osr = osr >> n;
        end else begin
            data     = osr >> (6'd32 - n);
            next_osr = osr << n;
        end
    end

endmodule

// File: rtl/pio_osr.sv
// Output shift register of a PIO state machine (reading end of the TX fifo).
// Loads 32-bit words via explicit PULL or autopull and serves 1..32 bits per OUT.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fifo read side (empty/dout/pull) and core side
//                (out/pull requests, OUT result, stall, shift_count)
//
// state     | meaning
// ----------|-------------------------------------------------------------
// READY     | accepting requests; PULL or autopull refill issues fifo_pull
// PULL_WAIT | fifo read data arrives; loads OSR, empties shift_count to 0
module pio_osr
    import pio_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    pio_osr_if.slave bus
);

    osr_state_t            state_q, state_d;
    logic [PIO_DATA_W-1:0] osr_q, osr_d;
    logic [PIO_DATA_W-1:0] out_data_q, out_data_d;
    logic [PIO_CNT_W-1:0]  shift_count_q, shift_count_d;
    logic                  out_valid_q, out_valid_d;
    logic                  fifo_pull, stall;
    logic [PIO_DATA_W-1:0] sh_data, sh_next;
    logic [PIO_CNT_W-1:0]  out_n, thresh_eff;
    logic [PIO_CNT_W:0]    count_sum;

    assign out_n      = eff_count(bus.out_count);
    assign thresh_eff = eff_count(bus.pull_thresh);
    assign count_sum  = {1'b0, shift_count_q} + {1'b0, out_n};

    pio_osr_shifter u_shifter (
        .osr         (osr_q),
        .n           (out_n),
        .shift_right (bus.shift_right),
        .data        (sh_data),
        .next_osr    (sh_next)
    );

    always_comb begin
        state_d       = state_q;
        osr_d         = osr_q;
        shift_count_d = shift_count_q;
        out_data_d    = out_data_q;
        out_valid_d   = 1'b0;
        fifo_pull     = 1'b0;
        stall         = 1'b0;
        if (!reset) begin
            case (state_q)
                READY: begin
                    if (bus.pull_req) begin
                        if (!bus.fifo_empty) begin
                            fifo_pull = 1'b1;
                            stall     = 1'b1;
                            state_d   = PULL_WAIT;
                        end else if (bus.pull_block) begin
                            stall = 1'b1;
                        end else begin
                            osr_d         = bus.x_data;
                            shift_count_d = '0;
                        end
                    end else if (bus.out_req) begin
                        // Autopull refill runs first; the held OUT is taken on return to READY.
                        if (bus.autopull && (shift_count_q >= thresh_eff)) begin
                            stall = 1'b1;
                            if (!bus.fifo_empty) begin
                                fifo_pull = 1'b1;
                                state_d   = PULL_WAIT;
                            end
                        end else begin
                            out_data_d    = sh_data;
                            osr_d         = sh_next;
                            shift_count_d = (count_sum > 7'd32) ? 6'd32 : count_sum[PIO_CNT_W-1:0];
                            out_valid_d   = 1'b1;
                        end
                    end
                end
                PULL_WAIT: begin
                    stall         = 1'b1;
                    osr_d         = bus.fifo_dout;
                    shift_count_d = '0;
                    state_d       = READY;
                end
                default: state_d = READY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= READY;
            osr_q         <= '0;
            shift_count_q <= 6'd32;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            osr_q         <= osr_d;
            shift_count_q <= shift_count_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign bus.fifo_pull   = fifo_pull;
    assign bus.stall       = stall;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.shift_count = shift_count_q;

endmodule
